mult_issue_ctrl: RTL and testbench

//   Sequences RV32M multiplies (MUL/MULH/MULHSU/MULHU) onto one free-running
//   33x33 DW02_mult_3_stage instance with tc=1. Forms the 33-bit operands and

---
 rtl/mult_issue_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mult_issue_ctrl
//   Issue controller for RV32M multiplies (MUL/MULH/MULHSU/MULHU) feeding one
//   free-running, enable-less 33x33 signed pipelined multiplier (tc tied 1).
//   It builds the sign/zero-extended 33-bit operands, tracks op+tag of every
//   product in flight, and parks finished results in a small FIFO. Because
//   requests are only accepted while outstanding < RES_DEPTH, every product
//   that comes out of the multiplier is guaranteed a FIFO slot, so consumer
//   backpressure never has to stall the multiplier.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready, i_req_op, i_req_rs1, i_req_rs2, i_req_tag
//                     request handshake; op 00 MUL 01 MULH 10 MULHSU 11 MULHU
//   i_flush           drop all outstanding work
//   o_resp_valid/i_resp_ready, o_resp_data, o_resp_tag
//                     in-order result handshake (FIFO head)
//   o_mult_a, o_mult_b, o_mult_tc, i_mult_product
//                     multiplier interface (operands registered)
//   o_busy            at least one op outstanding
// ---------------------------------------------------------------------------
module mult_issue_ctrl #(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 6,
    parameter int MULT_LAT  = 2,
    parameter int RES_DEPTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [1:0]           i_req_op,
    input  logic [XLEN-1:0]      i_req_rs1,
    input  logic [XLEN-1:0]      i_req_rs2,
    input  logic [TAG_W-1:0]     i_req_tag,
    input  logic                 i_flush,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic [XLEN-1:0]      o_resp_data,
    output logic [TAG_W-1:0]     o_resp_tag,
    output logic [XLEN:0]        o_mult_a,
    output logic [XLEN:0]        o_mult_b,
    output logic                 o_mult_tc,
    input  logic [2*XLEN+1:0]    i_mult_product,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_fifo_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [XLEN-1:0]  r_mem_data [RES_DEPTH];
    logic [TAG_W-1:0] r_mem_tag  [RES_DEPTH];
    logic [XLEN:0]    r_mult_a;
    logic [XLEN:0]    r_mult_b;
    logic [MULT_LAT:0] r_trk_valid;
    logic [1:0]       r_trk_op  [MULT_LAT+1];
    logic [TAG_W-1:0] r_trk_tag [MULT_LAT+1];

    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic             w_a_ext;
    logic             w_b_ext;
    logic [XLEN-1:0]  w_push_data;
    logic [1:0]       w_unused_prod_msbs;

    // Ready depends only on registered occupancy and flush, never on the
    // consumer side, so no combinational path from i_resp_ready exists.
    assign o_req_ready  = !i_flush && (r_outstanding < CNT_W'(RES_DEPTH));
    assign w_accept     = i_req_valid && o_req_ready;
    assign o_resp_valid = (r_fifo_cnt != '0);
    assign w_pop        = o_resp_valid && i_resp_ready;
    assign o_resp_data  = r_mem_data[r_rd_ptr];
    assign o_resp_tag   = r_mem_tag[r_rd_ptr];
    assign o_busy       = (r_outstanding != '0);
    assign o_mult_a     = r_mult_a;
    assign o_mult_b     = r_mult_b;
    assign o_mult_tc    = 1'b1;

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH; the 33rd bit carries it.
    assign w_a_ext = ((i_req_op == OP_MULH) || (i_req_op == OP_MULHSU)) && i_req_rs1[XLEN-1];
    assign w_b_ext = (i_req_op == OP_MULH) && i_req_rs2[XLEN-1];

    // A product whose tracker slot was killed by flush this cycle is dropped.
    assign w_push      = r_trk_valid[MULT_LAT] && !i_flush;
    assign w_push_data = (r_trk_op[MULT_LAT] == OP_MUL) ? i_mult_product[XLEN-1:0]
                                                        : i_mult_product[2*XLEN-1:XLEN];
    assign w_unused_prod_msbs = i_mult_product[2*XLEN+1:2*XLEN];

    // Operand registers: zero when idle so the multiplier sees clean inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mult_a <= '0;
            r_mult_b <= '0;
        end else if (w_accept) begin
            r_mult_a <= {w_a_ext, i_req_rs1};
            r_mult_b <= {w_b_ext, i_req_rs2};
        end else begin
            r_mult_a <= '0;
            r_mult_b <= '0;
        end
    end

    // Tracker: stage 0 lines up with the operand registers, stage MULT_LAT
    // lines up with the product of that same op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trk_valid <= '0;
            for (int k = 0; k <= MULT_LAT; k++) begin
                r_trk_op[k]  <= '0;
                r_trk_tag[k] <= '0;
            end
        end else begin
            r_trk_valid[0] <= w_accept;
            r_trk_op[0]    <= i_req_op;
            r_trk_tag[0]   <= i_req_tag;
            for (int k = 1; k <= MULT_LAT; k++) begin
                r_trk_valid[k] <= r_trk_valid[k-1];
                r_trk_op[k]    <= r_trk_op[k-1];
                r_trk_tag[k]   <= r_trk_tag[k-1];
            end
            if (i_flush) begin
                r_trk_valid <= '0;
            end
        end
    end

    // Result FIFO with modulo-RES_DEPTH pointers; storage is reset so the
    // response outputs read as zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            for (int k = 0; k < RES_DEPTH; k++) begin
                r_mem_data[k] <= '0;
                r_mem_tag[k]  <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_push_data;
                r_mem_tag[r_wr_ptr]  <= r_trk_tag[MULT_LAT];
                r_wr_ptr <= (r_wr_ptr == PTR_W'(RES_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(RES_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Outstanding = accepted but not yet popped; bounds FIFO occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (i_flush) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_issue_ctrl
//   Self-checking bench for mult_issue_ctrl. Includes a behavioural model of
//   the 2-stage 33x33 signed multiplier, a scoreboard queue of expected
//   {tag,data} pushed on accept and popped on each response handshake.
// ---------------------------------------------------------------------------
module tb_mult_issue_ctrl;

    localparam logic [1:0] MUL    = 2'b00;
    localparam logic [1:0] MULH   = 2'b01;
    localparam logic [1:0] MULHSU = 2'b10;
    localparam logic [1:0] MULHU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [5:0]  req_tag;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [5:0]  resp_tag;
    logic [32:0] mult_a;
    logic [32:0] mult_b;
    logic        mult_tc;
    logic [65:0] mult_product;
    logic        busy;

    logic [65:0] prodStage1;
    logic [65:0] prodStage2;

    logic [37:0] sb[$];
    int          checkCount;
    int          passCount;
    bit          holdValid;
    logic [31:0] holdData;
    logic [5:0]  holdTag;

    mult_issue_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_op       (req_op),
        .i_req_rs1      (req_rs1),
        .i_req_rs2      (req_rs2),
        .i_req_tag      (req_tag),
        .i_flush        (flush),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_data    (resp_data),
        .o_resp_tag     (resp_tag),
        .o_mult_a       (mult_a),
        .o_mult_b       (mult_b),
        .o_mult_tc      (mult_tc),
        .i_mult_product (mult_product),
        .o_busy         (busy)
    );

    // Clock generation, 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running two-stage signed multiplier model (no enable, no reset)
    always @(posedge clk) begin
        prodStage1 <= {{33{mult_a[32]}}, mult_a} * {{33{mult_b[32]}}, mult_b};
        prodStage2 <= prodStage1;
    end
    assign mult_product = prodStage2;

    // Reference RV32M result computed with 64-bit arithmetic
    function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb64;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb64 = longint'($signed(b));
        case (op)
            MULH:    p = sa * sb64;
            MULHSU:  p = sa * longint'({32'b0, b});
            MULHU:   p = {32'b0, a} * {32'b0, b};
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    // Single comparison point: counts and reports
    task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of request inputs; push expectation when accepted
    task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [5:0] tag,
                                 input logic [31:0] expData, output bit accepted);
        @(posedge clk);
        #1;
        req_valid = v;
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_tag   = tag;
        #1;
        accepted = v && req_ready;
        if (accepted) sb.push_back({tag, expData});
    endtask

    task automatic stepIdle();
        bit acc;
        applyStimulus(1'b0, MUL, 32'h0, 32'h0, 6'h0, 32'h0, acc);
    endtask

    task automatic waitDrain(input int maxCycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < maxCycles) begin
            stepIdle();
            n++;
        end
        checkOutput("drain_timeout", 66'(sb.size()), 66'd0);
    endtask

    // Response monitor: pops scoreboard on handshake, checks hold stability
    always @(negedge clk) begin
        logic [37:0] exp;
        if (!rst_n) begin
            holdValid = 1'b0;
        end else begin
            if (holdValid && resp_valid) begin
                checkOutput("hold_data", 66'(resp_data), 66'(holdData));
                checkOutput("hold_tag", 66'(resp_tag), 66'(holdTag));
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("resp_unexpected", 66'd1, 66'd0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("resp_tag", 66'(resp_tag), 66'(exp[37:32]));
                    checkOutput("resp_data", 66'(resp_data), 66'(exp[31:0]));
                end
            end
            if (flush) sb.delete();
            if (sb.size() > 5) checkOutput("sb_overflow", 66'(sb.size()), 66'd5);
            holdValid = resp_valid && !resp_ready && !flush;
            holdData  = resp_data;
            holdTag   = resp_tag;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          acc;
        int          idx;
        int          n;
        logic [1:0]  ops   [7];
        logic [31:0] rsA   [7];
        logic [31:0] rsB   [7];
        logic [31:0] a;
        logic [31:0] b;

        checkCount = 0;
        passCount  = 0;
        holdValid  = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = MUL;
        req_rs1    = '0;
        req_rs2    = '0;
        req_tag    = '0;
        flush      = 1'b0;
        resp_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("rst_resp_valid", 66'(resp_valid), 66'd0);
        checkOutput("rst_resp_data", 66'(resp_data), 66'd0);
        checkOutput("rst_resp_tag", 66'(resp_tag), 66'd0);
        checkOutput("rst_mult_a", 66'(mult_a), 66'd0);
        checkOutput("rst_mult_b", 66'(mult_b), 66'd0);
        checkOutput("rst_busy", 66'(busy), 66'd0);
        checkOutput("mult_tc", 66'(mult_tc), 66'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_req_ready", 66'(req_ready), 66'd1);

        // Test 1: MULH latency and operand formation
        $display("[TB] test 1: MULH latency");
        applyStimulus(1'b1, MULH, 32'h8000_0000, 32'h8000_0000, 6'd3, 32'h4000_0000, acc);
        checkOutput("t1_accept", 66'(acc), 66'd1);
        stepIdle();
        checkOutput("t1_mult_a", 66'(mult_a), 66'h1_8000_0000);
        checkOutput("t1_mult_b", 66'(mult_b), 66'h1_8000_0000);
        checkOutput("t1_busy", 66'(busy), 66'd1);
        checkOutput("t1_valid_c1", 66'(resp_valid), 66'd0);
        stepIdle();
        checkOutput("t1_mult_a_idle", 66'(mult_a), 66'd0);
        checkOutput("t1_valid_c2", 66'(resp_valid), 66'd0);
        stepIdle();
        checkOutput("t1_valid_c3", 66'(resp_valid), 66'd0);
        stepIdle();
        checkOutput("t1_valid_c4", 66'(resp_valid), 66'd1);
        checkOutput("t1_tag_c4", 66'(resp_tag), 66'd3);
        waitDrain(10);

        // Test 2: all four ops on rs1=-1, rs2=2
        $display("[TB] test 2: op variants");
        applyStimulus(1'b1, MULHSU, 32'hFFFF_FFFF, 32'h2, 6'd10, 32'hFFFF_FFFF, acc);
        checkOutput("t2_acc0", 66'(acc), 66'd1);
        applyStimulus(1'b1, MULHU, 32'hFFFF_FFFF, 32'h2, 6'd11, 32'h0000_0001, acc);
        checkOutput("t2_acc1", 66'(acc), 66'd1);
        applyStimulus(1'b1, MUL, 32'hFFFF_FFFF, 32'h2, 6'd12, 32'hFFFF_FFFE, acc);
        checkOutput("t2_acc2", 66'(acc), 66'd1);
        applyStimulus(1'b1, MULH, 32'hFFFF_FFFF, 32'h2, 6'd13, 32'hFFFF_FFFF, acc);
        checkOutput("t2_acc3", 66'(acc), 66'd1);
        waitDrain(12);

        // Test 3: 8 back-to-back MULs, one response per cycle
        $display("[TB] test 3: back-to-back throughput");
        for (int c = 0; c < 13; c++) begin
            if (c < 8) begin
                a = $urandom;
                b = $urandom;
                applyStimulus(1'b1, MUL, a, b, 6'(c), refMul(MUL, a, b), acc);
                checkOutput("t3_accept", 66'(acc), 66'd1);
            end else begin
                stepIdle();
            end
            if (c >= 4 && c < 12) checkOutput("t3_resp_valid", 66'(resp_valid), 66'd1);
            if (c == 12) checkOutput("t3_resp_idle", 66'(resp_valid), 66'd0);
        end
        waitDrain(10);

        // Test 4: backpressure caps acceptance at FIFO depth
        $display("[TB] test 4: backpressure");
        for (int i = 0; i < 7; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            rsA[i] = $urandom;
            rsB[i] = $urandom;
        end
        resp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b1, ops[idx], rsA[idx], rsB[idx], 6'(20 + idx),
                          refMul(ops[idx], rsA[idx], rsB[idx]), acc);
            if (acc) idx++;
        end
        checkOutput("t4_accepted", 66'(idx), 66'd5);
        checkOutput("t4_req_ready", 66'(req_ready), 66'd0);
        checkOutput("t4_busy", 66'(busy), 66'd1);
        resp_ready = 1'b1;
        n = 0;
        while (idx < 7 && n < 30) begin
            applyStimulus(1'b1, ops[idx], rsA[idx], rsB[idx], 6'(20 + idx),
                          refMul(ops[idx], rsA[idx], rsB[idx]), acc);
            if (acc) idx++;
            n++;
        end
        checkOutput("t4_remaining", 66'(idx), 66'd7);
        waitDrain(20);

        // Test 5: flush with 2 queued and 3 in flight
        $display("[TB] test 5: flush");
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            applyStimulus(1'b1, MUL, a, b, 6'(30 + i), refMul(MUL, a, b), acc);
            checkOutput("t5_accept", 66'(acc), 66'd1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b1;
        #1;
        checkOutput("t5_flush_ready", 66'(req_ready), 66'd0);
        checkOutput("t5_queued", 66'(resp_valid), 66'd1);
        @(posedge clk);
        #1;
        flush      = 1'b0;
        resp_ready = 1'b1;
        #1;
        checkOutput("t5_post_valid", 66'(resp_valid), 66'd0);
        checkOutput("t5_post_busy", 66'(busy), 66'd0);
        checkOutput("t5_post_ready", 66'(req_ready), 66'd1);
        for (int c = 0; c < 6; c++) begin
            stepIdle();
            checkOutput("t5_no_resp", 66'(resp_valid), 66'd0);
        end
        applyStimulus(1'b1, MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 6'd40,
                      refMul(MULHU, 32'hDEAD_BEEF, 32'h1234_5678), acc);
        checkOutput("t5_new_accept", 66'(acc), 66'd1);
        waitDrain(10);

        // Test 6: reset mid-stream
        $display("[TB] test 6: reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            applyStimulus(1'b1, MULHSU, a, b, 6'(50 + i), refMul(MULHSU, a, b), acc);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        sb.delete();
        #1;
        checkOutput("t6_resp_valid", 66'(resp_valid), 66'd0);
        checkOutput("t6_resp_data", 66'(resp_data), 66'd0);
        checkOutput("t6_resp_tag", 66'(resp_tag), 66'd0);
        checkOutput("t6_mult_a", 66'(mult_a), 66'd0);
        checkOutput("t6_mult_b", 66'(mult_b), 66'd0);
        checkOutput("t6_busy", 66'(busy), 66'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("t6_req_ready", 66'(req_ready), 66'd1);
        for (int c = 0; c < 8; c++) begin
            stepIdle();
            checkOutput("t6_no_stale", 66'(resp_valid), 66'd0);
        end
        applyStimulus(1'b1, MULH, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 6'd60,
                      refMul(MULH, 32'h7FFF_FFFF, 32'hFFFF_FFFE), acc);
        checkOutput("t6_new_accept", 66'(acc), 66'd1);
        waitDrain(10);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
